alu_seq: RTL and testbench

Sequential, handshaked successor to the single-cycle combinational ALU in the execute stage. It is parametrised in datapath width. It registers every result, and it adds the RV32M multiply/divide operations, executed iteratively over a shared shift-add/shift-subtract engine. It sits between operand fetch and writeback, and stalls the pipe through a valid/ready handshake while a long operation runs.

---
 rtl/alu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// alu_seq: registered, valid/ready-handshaked execute-stage ALU with an optional
// iterative RV32M multiply/divide engine enabled by defining ALU_SEQ_MDU_EN.
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [5:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [5:0] OP_ADD    = 6'h01, OP_SUB   = 6'h02, OP_SLL   = 6'h03,
                         OP_SLT    = 6'h04, OP_SLTU  = 6'h05, OP_XOR   = 6'h06,
                         OP_SRL    = 6'h07, OP_SRA   = 6'h08, OP_OR    = 6'h09,
                         OP_AND    = 6'h0A, OP_ADDI  = 6'h0B, OP_SLLI  = 6'h0C,
                         OP_SLTI   = 6'h0D, OP_SLTIU = 6'h0E, OP_XORI  = 6'h0F,
                         OP_SRLI   = 6'h10, OP_ORI   = 6'h11, OP_ANDI  = 6'h12,
                         OP_SRAI   = 6'h13, OP_EQ    = 6'h1B, OP_NE    = 6'h1C,
                         OP_GE     = 6'h1F, OP_LT    = 6'h20, OP_MUL   = 6'h21,
                         OP_MULH   = 6'h22, OP_MULHSU = 6'h23, OP_MULHU = 6'h24,
                         OP_DIV    = 6'h25, OP_DIVU  = 6'h26, OP_REM   = 6'h27,
                         OP_REMU   = 6'h28;

`ifdef ALU_SEQ_MDU_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
`else
  typedef enum logic {S_IDLE, S_DONE} state_e;
`endif

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              accept;

  // Single-step results; the divide cases only arrive here with a zero divisor.
  function automatic logic [XLEN-1:0] single_op(input logic [5:0]      op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    logic [SHW-1:0]  sh;
    sh  = b[SHW-1:0];
    res = '0;
    case (op)
      OP_ADD, OP_ADDI:    res = a + b;
      OP_SUB:             res = a - b;
      OP_SLL, OP_SLLI:    res = a << sh;
      OP_SLT, OP_SLTI:    res[0] = $signed(a) < $signed(b);
      OP_SLTU, OP_SLTIU:  res[0] = a < b;
      OP_XOR, OP_XORI:    res = a ^ b;
      OP_SRL, OP_SRLI:    res = a >> sh;
      OP_SRA, OP_SRAI:    res = $signed(a) >>> sh;
      OP_OR, OP_ORI:      res = a | b;
      OP_AND, OP_ANDI:    res = a & b;
      OP_EQ:              res[0] = a == b;
      OP_NE:              res[0] = a != b;
      OP_GE:              res[0] = $signed(a) >= $signed(b);
      OP_LT:              res[0] = $signed(a) < $signed(b);
`ifdef ALU_SEQ_MDU_EN
      OP_DIV, OP_DIVU:    res = '1;
      OP_REM, OP_REMU:    res = a;
`endif
      default:            res = '0;
    endcase
    return res;
  endfunction

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

`ifdef ALU_SEQ_MDU_EN
  // acc holds {hi, lo}: product halves for multiply, {remainder, dividend/quotient} for divide.
  logic [5:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, acc_step, acc_prep, prod;
  logic [XLEN-1:0]     opnd_q, opnd_d, opnd_prep, mag_a, mag_b, quot, rem, mdu_result;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic                prep_q, prep_d, neg_q, neg_d, rneg_q, rneg_d;
  logic                is_mul, a_signed, b_signed, a_neg, b_neg, start_multi;
  logic [XLEN:0]       mul_sum, div_rs, div_diff;

  assign busy   = (state_q == S_BUSY);
  assign is_mul = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign start_multi = (alu_control inside {[OP_MUL:OP_REMU]}) &&
                       !((alu_control inside {[OP_DIV:OP_REMU]}) && src2 == '0);

  always_comb begin
    a_signed  = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed  = op_q inside {OP_MULH, OP_DIV, OP_REM};
    a_neg     = a_signed && acc_q[XLEN-1];
    b_neg     = b_signed && opnd_q[XLEN-1];
    mag_a     = a_neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    mag_b     = b_neg ? -opnd_q : opnd_q;
    acc_prep  = is_mul ? {{XLEN{1'b0}}, mag_b} : {{XLEN{1'b0}}, mag_a};
    opnd_prep = is_mul ? mag_a : mag_b;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rs - {1'b0, opnd_q};
    if (is_mul)
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    else
      acc_step = {div_diff[XLEN] ? div_rs[XLEN-1:0] : div_diff[XLEN-1:0],
                  acc_q[XLEN-2:0], ~div_diff[XLEN]};

    prod = neg_q  ? -acc_step : acc_step;
    quot = neg_q  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        mdu_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  mdu_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               mdu_result = quot;
      default:                       mdu_result = rem;
    endcase
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_SEQ_MDU_EN
    op_d   = op_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    prep_d = prep_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
        if (accept) begin
`ifdef ALU_SEQ_MDU_EN
          if (start_multi) begin
            state_d = S_BUSY;
            op_d    = alu_control;
            acc_d   = {{XLEN{1'b0}}, src1};
            opnd_d  = src2;
            cnt_d   = '0;
            prep_d  = 1'b1;
          end else
`endif
          begin
            state_d  = S_DONE;
            result_d = single_op(alu_control, src1, src2);
          end
        end
      end
`ifdef ALU_SEQ_MDU_EN
      S_BUSY: begin
        // First BUSY cycle turns the raw operands into magnitudes and sign flags.
        if (prep_q) begin
          prep_d = 1'b0;
          acc_d  = acc_prep;
          opnd_d = opnd_prep;
          neg_d  = a_neg ^ b_neg;
          rneg_d = !is_mul && a_neg;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            state_d  = S_DONE;
            result_d = mdu_result;
            cnt_d    = '0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
`ifdef ALU_SEQ_MDU_EN
      cnt_q    <= '0;
      prep_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifdef ALU_SEQ_MDU_EN
      cnt_q    <= cnt_d;
      prep_q   <= prep_d;
`endif
    end
  end

`ifdef ALU_SEQ_MDU_EN
  // NOTE: engine datapath has no reset; it is always reloaded on acceptance before use.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// Self-checking bench for alu_seq: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_seq;
  localparam int XLEN = 32;
`ifdef ALU_SEQ_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src1, src2;
  logic [5:0]      alu_control;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int          sa, sb;
    int unsigned sh;
    logic [63:0] p;
    sa = a;
    sb = b;
    sh = 32'(b[4:0]);
    if (!MDU_EN && op >= 6'h21 && op <= 6'h28) return 32'h0;
    case (op)
      6'h01, 6'h0B: return a + b;
      6'h02:        return a - b;
      6'h03, 6'h0C: return a << sh;
      6'h04, 6'h0D: return (sa < sb) ? 32'd1 : 32'd0;
      6'h05, 6'h0E: return (a < b) ? 32'd1 : 32'd0;
      6'h06, 6'h0F: return a ^ b;
      6'h07, 6'h10: return a >> sh;
      6'h08, 6'h13: return sa >>> sh;
      6'h09, 6'h11: return a | b;
      6'h0A, 6'h12: return a & b;
      6'h1B:        return (a == b) ? 32'd1 : 32'd0;
      6'h1C:        return (a != b) ? 32'd1 : 32'd0;
      6'h1F:        return (sa >= sb) ? 32'd1 : 32'd0;
      6'h20:        return (sa < sb) ? 32'd1 : 32'd0;
      6'h21:        return a * b;
      6'h22: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      6'h23: begin p = {{32{a[31]}}, a} * {32'h0, b};       return p[63:32]; end
      6'h24: begin p = {32'h0, a} * {32'h0, b};             return p[63:32]; end
      6'h25: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      6'h26: return (b == 0) ? 32'hFFFFFFFF : a / b;
      6'h27: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      6'h28: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_multi(input logic [5:0] op, input logic [31:0] b);
    return MDU_EN && op >= 6'h21 && op <= 6'h28 && !(op >= 6'h25 && b == 0);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Offer one op from IDLE with out_ready high; check timing, busy, result and drain.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int   edges;
    int   ready_while_wait;
    bit   saw_busy;
    bit   multi;
    multi = is_multi(op, b);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; src1 = a; src2 = b; alu_control = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = $urandom; src2 = $urandom; alu_control = 6'($urandom);
    edges = 0; ready_while_wait = 0; saw_busy = 1'b0;
    while (!out_valid && edges < 100) begin
      if (in_ready) ready_while_wait++;
      if (busy) saw_busy = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".edges_after_accept"}, 32'(edges), multi ? 32'(XLEN + 1) : 32'd0);
    check({tag, ".result"}, result, model(op, a, b));
    check({tag, ".busy_seen"}, 32'(saw_busy), 32'(multi));
    check({tag, ".in_ready_while_busy"}, 32'(ready_while_wait), 32'd0);
    @(posedge clk); #1;
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [5:0] op_list[] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                            6'h10, 6'h11, 6'h12, 6'h13, 6'h1B, 6'h1C, 6'h1D, 6'h1F,
                            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h28, 6'h3F};

  initial begin
    logic [31:0] held;
    int          unstable;
    bit          saw_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; alu_control = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-step ops at full throughput.
    in_valid = 1'b1; out_ready = 1'b1;
    src1 = 32'h7FFFFFFF; src2 = 32'h1; alu_control = 6'h01;
    @(posedge clk); #1;
    check("b2b.add.valid", 32'(out_valid), 32'd1);
    check("b2b.add.result", result, 32'h80000000);
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    src1 = 32'h80000000; src2 = 32'd4; alu_control = 6'h08;
    @(posedge clk); #1;
    check("b2b.sra.valid", 32'(out_valid), 32'd1);
    check("b2b.sra.result", result, 32'hF8000000);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b.drained", 32'(out_valid), 32'd0);

    // Directed multiply/divide corners.
    run_op("mulh", 6'h22, 32'hFFFFFFFE, 32'd3);
    run_op("mulhu", 6'h24, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mul", 6'h21, 32'd6, 32'd7);
    run_op("div_neg", 6'h25, 32'hFFFFFFF9, 32'd2);
    run_op("rem_neg", 6'h27, 32'hFFFFFFF9, 32'd2);
    run_op("div_ovf", 6'h25, 32'h80000000, 32'hFFFFFFFF);
    run_op("rem_ovf", 6'h27, 32'h80000000, 32'hFFFFFFFF);
    run_op("remu_by0", 6'h28, 32'd5, 32'd0);
    run_op("div_by0", 6'h25, 32'd5, 32'd0);

    // Backpressure: result held, then accept-and-complete on the same edge.
    in_valid = 1'b1; out_ready = 1'b0;
    src1 = 32'h12345678; src2 = 32'h11111111; alu_control = 6'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    held = result;
    check("bp.result", held, 32'h01234567);
    unstable = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
    end
    check("bp.stable_cycles_bad", 32'(unstable), 32'd0);
    check("bp.in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1;
    src1 = 32'hF0F0F0F0; src2 = 32'h0FF00FF0; alu_control = 6'h06;
    #1 check("bp.in_ready_on_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.new_valid", 32'(out_valid), 32'd1);
    check("bp.new_result", result, 32'hFF00FF00);
    @(posedge clk); #1;
    check("bp.drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a DIVU (or while its result is held back).
    in_valid = 1'b1; out_ready = 1'b0;
    src1 = 32'd1000; src2 = 32'd7; alu_control = 6'h26;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.result", result, 32'h0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) saw_valid = 1'b1;
    end
    check("rst_mid.no_stale", 32'(saw_valid), 32'd0);

    // Randomized ops with corner-biased operands.
    for (int i = 0; i < 200; i++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      op = op_list[$urandom_range(0, op_list.size() - 1)];
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d_op%02h", i, op), op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
